// File: rtl/mul_seq_booth_if.sv
// mul_seq_booth_if: start/done handshake bundle for mul_seq_booth (sgn present only with MUL_SEQ_UNSIGNED_EN)
interface mul_seq_booth_if #(parameter int WIDTH = 8);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] y;
`ifdef MUL_SEQ_UNSIGNED_EN
  logic               sgn;
  modport master(output start, a, b, sgn, input busy, done, y);
  modport slave(input start, a, b, sgn, output busy, done, y);
`else
  modport master(output start, a, b, input busy, done, y);
  modport slave(input start, a, b, output busy, done, y);
`endif
endinterface

// File: rtl/mul_seq_booth.sv
// mul_seq_booth: radix-2 Booth sequential signed multiplier, one step per clock
// MUL_SEQ_UNSIGNED_EN adds bus.sgn to select signed/unsigned operands (one extra step)
module mul_seq_booth #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  mul_seq_booth_if.slave  bus
);
`ifdef MUL_SEQ_UNSIGNED_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam int CW = $clog2(EW + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [EW:0]        acc_q, acc_d, acc_sel, acc_n;
  logic [EW-1:0]      mcand_q, mcand_d, q_q, q_d, q_n, a_ext, b_ext;
  logic               qm_q, qm_d, qm_n;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic [2*EW-1:0]    prod;
`ifdef MUL_SEQ_UNSIGNED_EN
  assign a_ext = {bus.sgn & bus.a[WIDTH-1], bus.a};
  assign b_ext = {bus.sgn & bus.b[WIDTH-1], bus.b};
`else
  assign a_ext = bus.a;
  assign b_ext = bus.b;
`endif
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    acc_sel = (q_q[0] & ~qm_q) ? acc_q - {mcand_q[EW-1], mcand_q} :
              (~q_q[0] & qm_q) ? acc_q + {mcand_q[EW-1], mcand_q} : acc_q;
    {acc_n, q_n, qm_n} = {acc_sel[EW], acc_sel, q_q};
    prod    = {acc_n[EW-1:0], q_n};
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        mcand_d = a_ext;
        q_d     = b_ext;
        qm_d    = 1'b0;
        acc_d   = '0;
        cnt_d   = CW'(EW);
      end
      RUN: begin
        acc_d = acc_n;
        q_d   = q_n;
        qm_d  = qm_n;
        cnt_d = cnt_q - CW'(1);
        // load y on the final step so it is already valid while done is high
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          y_d     = prod[2*WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      qm_q    <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.y    = y_q;
endmodule
